wtank_ctrl: RTL

Overhead-tank pump controller that sits directly upstream of the smart restroom controller. It debounces the tank's low and high level probes and runs the fill motor with a fill timeout and a minimum off time. It produces the `water_level` flag that the restroom block consumes, where 1 means water is available and 0 means the restroom is locked and the owner is alerted. It also reports dry-run and sensor faults and keeps a saturating count of completed fills.

---
 rtl/wtank_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/wtank_ctrl.sv
// -----------------------------------------------------------------------------
// wtank_ctrl: overhead-tank pump controller.
//   Synchronises and debounces the tank low/high level probes, runs the fill
//   motor with a fill timeout (dry-run fault) and a minimum rest time after
//   every stop, and produces the water_level flag for the restroom block.
//
// Ports
//   clk          in   single rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   lvl_lo_raw   in   async probe, 1 = water above low probe
//   lvl_hi_raw   in   async probe, 1 = water at/above high probe (full)
//   fault_clr    in   sync pulse, acknowledges a fault (FAULT state only)
//   water_level  out  registered, 1 = water usable
//   motor_on     out  1 = pump running (decoded from state register)
//   dry_fault    out  1 = block is in FAULT
//   fill_count   out  completed fills, saturates at 255
//   state        out  IDLE=00 FILL=01 REST=10 FAULT=11
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | motor off, waiting for the filtered low level to drop
// FILL    | motor on, fill timer running until high probe or timeout
// REST    | motor off for MIN_OFF cycles, level changes ignored
// FAULT   | dry-run or sensor inconsistency, waits for fault_clr
// -----------------------------------------------------------------------------
module wtank_ctrl #(
    parameter int DEB_CYC      = 4,
    parameter int FILL_TIMEOUT = 1000,
    parameter int MIN_OFF      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lvl_lo_raw,
    input  logic       lvl_hi_raw,
    input  logic       fault_clr,
    output logic       water_level,
    output logic       motor_on,
    output logic       dry_fault,
    output logic [7:0] fill_count,
    output logic [1:0] state
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_FILL  = 2'b01;
    localparam logic [1:0] S_REST  = 2'b10;
    localparam logic [1:0] S_FAULT = 2'b11;

    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int FW = $clog2(FILL_TIMEOUT + 1);
    localparam int RW = $clog2(MIN_OFF + 1);

    // Bit 0 carries the low probe, bit 1 the high probe.
    logic [1:0]         sync1_q, sync2_q;
    logic [1:0]         filt_q, filt_d;
    logic [1:0][DW-1:0] deb_q, deb_d;

    logic [1:0]    state_q, state_d;
    logic [FW-1:0] fill_tmr_q, fill_tmr_d;
    logic [RW-1:0] rest_tmr_q, rest_tmr_d;
    logic [7:0]    fill_cnt_q, fill_cnt_d;
    logic          water_q, water_d;

    logic lo_f, hi_f, conflict;

    assign lo_f     = filt_q[0];
    assign hi_f     = filt_q[1];
    assign conflict = hi_f & ~lo_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {lvl_hi_raw, lvl_lo_raw};
            sync2_q <= sync1_q;
        end
    end

    // Counter tracks consecutive disagreeing cycles; the filtered value flips
    // on the DEB_CYC-th one, so the counter never needs to reach DEB_CYC.
    always_comb begin
        filt_d = filt_q;
        deb_d  = deb_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (deb_q[i] == DW'(DEB_CYC - 1)) begin
                    filt_d[i] = sync2_q[i];
                    deb_d[i]  = '0;
                end else begin
                    deb_d[i] = deb_q[i] + 1'b1;
                end
            end else begin
                deb_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= '0;
            deb_q  <= '0;
        end else begin
            filt_q <= filt_d;
            deb_q  <= deb_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fill_tmr_d = fill_tmr_q;
        rest_tmr_d = rest_tmr_q;
        fill_cnt_d = fill_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (conflict) begin
                    state_d = S_FAULT;
                end else if (!lo_f) begin
                    state_d    = S_FILL;
                    fill_tmr_d = '0;
                end
            end
            S_FILL: begin
                if (fill_tmr_q != FW'(FILL_TIMEOUT))
                    fill_tmr_d = fill_tmr_q + 1'b1;
                // Full tank beats the timeout when both land on one cycle.
                if (conflict) begin
                    state_d = S_FAULT;
                end else if (hi_f) begin
                    state_d    = S_REST;
                    rest_tmr_d = '0;
                    if (fill_cnt_q != 8'hFF)
                        fill_cnt_d = fill_cnt_q + 1'b1;
                end else if (fill_tmr_q == FW'(FILL_TIMEOUT - 1)) begin
                    state_d = S_FAULT;
                end
            end
            S_REST: begin
                if (rest_tmr_q == RW'(MIN_OFF - 1))
                    state_d = S_IDLE;
                else
                    rest_tmr_d = rest_tmr_q + 1'b1;
            end
            S_FAULT: begin
                if (fault_clr) begin
                    state_d    = S_REST;
                    rest_tmr_d = '0;
                end
            end
            default: begin
                state_d    = S_REST;
                rest_tmr_d = '0;
            end
        endcase
        // Looks at the next state so water_level drops on the FAULT entry edge.
        water_d = lo_f & (state_d != S_FAULT);
    end

    // Reset lands in REST so a reset mid-fill still enforces a full rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_REST;
            fill_tmr_q <= '0;
            rest_tmr_q <= '0;
            fill_cnt_q <= '0;
            water_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_tmr_q <= fill_tmr_d;
            rest_tmr_q <= rest_tmr_d;
            fill_cnt_q <= fill_cnt_d;
            water_q    <= water_d;
        end
    end

    assign state       = state_q;
    assign motor_on    = (state_q == S_FILL);
    assign dry_fault   = (state_q == S_FAULT);
    assign fill_count  = fill_cnt_q;
    assign water_level = water_q;

endmodule
